// File: rtl/instr_mem_bank_mux.sv
// Instruction-memory front end: decodes one req/gnt/rvalid port onto NUM_BANKS banks,
// with an optional read-only boot ROM in bank 0 and extra response wait states for slow banks.
module instr_mem_bank_mux #(
  parameter int                   NUM_BANKS       = 4,
  parameter int                   BANK_ADDR_WIDTH = 13,
  parameter int                   ADDR_WIDTH      = BANK_ADDR_WIDTH + $clog2(NUM_BANKS),
  parameter int                   DATA_WIDTH      = 32,
  parameter bit                   ROM_BANK_EN     = 1'b1,
  parameter logic [NUM_BANKS-1:0] SLOW_BANK_MASK  = {{(NUM_BANKS-1){1'b0}}, 1'b1},
  parameter int                   WAIT_CYCLES     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_i,
  output logic                            gnt_o,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic                            we_i,
  input  logic [DATA_WIDTH/8-1:0]         be_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  output logic                            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            err_o,
  output logic [NUM_BANKS-1:0]            bank_en_o,
  output logic [BANK_ADDR_WIDTH-1:0]      bank_addr_o,
  output logic                            bank_we_o,
  output logic [DATA_WIDTH/8-1:0]         bank_be_o,
  output logic [DATA_WIDTH-1:0]           bank_wdata_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata_i
);

  localparam int SEL_W     = ADDR_WIDTH - BANK_ADDR_WIDTH;
  localparam int NUM_SLOTS = 1 << SEL_W;
  localparam int CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, RSP, WAIT} state_t;

  state_t                 state;
  logic [SEL_W-1:0]       sel, sel_q;
  logic                   we_q, err_q, slow_q;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic                   rvalid_q, err_r;

  logic [NUM_BANKS-1:0]   bank_hit;
  logic                   sel_ok, rom_wr, err, slow, hs;

  // Read data padded to the full decode range so an out-of-range sel_q reads zero.
  logic [DATA_WIDTH-1:0]  bank_rdata [NUM_SLOTS];

  assign sel = addr_i[ADDR_WIDTH-1:BANK_ADDR_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_hit
      assign bank_hit[gi] = (sel == SEL_W'(gi));
    end
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_rdata
      if (gi < NUM_BANKS) begin : g_real
        assign bank_rdata[gi] = bank_rdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
        assign bank_rdata[gi] = '0;
      end
    end
  endgenerate

  assign sel_ok = |bank_hit;
  assign rom_wr = ROM_BANK_EN && bank_hit[0] && we_i;
  assign err    = ~sel_ok | rom_wr;
  assign slow   = (|(bank_hit & SLOW_BANK_MASK)) && (WAIT_CYCLES > 0) && ~err && ~we_i;

  assign gnt_o = req_i & (state != WAIT);
  assign hs    = req_i & gnt_o;

  assign bank_en_o    = (hs && !err) ? bank_hit : '0;
  assign bank_addr_o  = addr_i[BANK_ADDR_WIDTH-1:0];
  assign bank_we_o    = we_i;
  assign bank_be_o    = be_i;
  assign bank_wdata_o = wdata_i;

  assign rvalid_o = rvalid_q;
  assign err_o    = err_r;

  // Only legal reads return data; slow banks return the value captured in the first WAIT cycle.
  always_comb begin
    rdata_o = '0;
    if (rvalid_q && !we_q && !err_q) begin
      rdata_o = slow_q ? hold_q : bank_rdata[sel_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      slow_q   <= 1'b0;
      cnt      <= '0;
      hold_q   <= '0;
      rvalid_q <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE, RSP: begin
          rvalid_q <= hs & ~slow;
          err_r    <= hs & ~slow & err;
          if (hs) begin
            sel_q  <= sel;
            we_q   <= we_i;
            err_q  <= err;
            slow_q <= slow;
            if (slow) begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES);
            end else begin
              state <= RSP;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(WAIT_CYCLES)) begin
            hold_q <= bank_rdata[sel_q];
          end
          cnt      <= cnt - CNT_W'(1);
          rvalid_q <= (cnt == CNT_W'(1));
          err_r    <= 1'b0;
          if (cnt == CNT_W'(1)) begin
            state <= RSP;
          end
        end
        default: begin
          state    <= IDLE;
          rvalid_q <= 1'b0;
          err_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_bank_mux.sv
// Directed bench for instr_mem_bank_mux: a 4-bank default instance and a 3-bank instance
// exercising out-of-range decode.
module tb_instr_mem_bank_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: default parameters (4 banks, bank 0 slow ROM) ----------------
  logic        a_req = 0, a_we = 0;
  logic [14:0] a_addr = '0;
  logic [3:0]  a_be = '0;
  logic [31:0] a_wdata = '0;
  logic        a_gnt, a_rvalid, a_err, a_bwe;
  logic [31:0] a_rdata, a_bwdata;
  logic [3:0]  a_en, a_bbe;
  logic [12:0] a_baddr;
  logic [31:0] a_bank [4];
  logic [127:0] a_bank_rdata;
  assign a_bank_rdata = {a_bank[3], a_bank[2], a_bank[1], a_bank[0]};

  instr_mem_bank_mux dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr),
    .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
    .err_o(a_err), .bank_en_o(a_en), .bank_addr_o(a_baddr), .bank_we_o(a_bwe),
    .bank_be_o(a_bbe), .bank_wdata_o(a_bwdata), .bank_rdata_i(a_bank_rdata)
  );

  // ---------------- DUT B: 3 banks, top decode value is illegal ----------------
  logic        b_req = 0, b_we = 0;
  logic [14:0] b_addr = '0;
  logic [3:0]  b_be = '0;
  logic [31:0] b_wdata = '0;
  logic        b_gnt, b_rvalid, b_err, b_bwe;
  logic [31:0] b_rdata, b_bwdata;
  logic [2:0]  b_en;
  logic [3:0]  b_bbe;
  logic [12:0] b_baddr;
  logic [95:0] b_bank_rdata = {32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};

  instr_mem_bank_mux #(.NUM_BANKS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr),
    .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
    .err_o(b_err), .bank_en_o(b_en), .bank_addr_o(b_baddr), .bank_we_o(b_bwe),
    .bank_be_o(b_bbe), .bank_wdata_o(b_bwdata), .bank_rdata_i(b_bank_rdata)
  );

  typedef struct {
    logic [14:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  en;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [5];

  initial begin
    a_bank[0] = 32'h00000013;
    a_bank[1] = 32'hDEADBEEF;
    a_bank[2] = 32'h22222222;
    a_bank[3] = 32'h33333333;

    vecs[0] = '{15'h2004, 1'b0, 4'hF, 32'h0,        4'b0010, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{15'h0020, 1'b1, 4'hF, 32'h11223344, 4'b0000, 1'b1, 32'h0};
    vecs[2] = '{15'h4008, 1'b1, 4'h3, 32'hCAFEF00D, 4'b0100, 1'b0, 32'h0};
    vecs[3] = '{15'h6010, 1'b0, 4'hF, 32'h0,        4'b1000, 1'b0, 32'h33333333};
    vecs[4] = '{15'h6000, 1'b1, 4'h1, 32'h5A5A5A5A, 4'b1000, 1'b0, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_en", a_en, 0);
    a_req = 1; #1;
    chk("rst_gnt_follows_req", a_gnt, 1);
    chk("rst_en_no_hs_effect", a_rvalid, 0);
    a_req = 0;
    rst_n = 1;

    // Single fast transactions, one per vector
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_req = 1; a_addr = vecs[i].addr; a_we = vecs[i].we;
      a_be = vecs[i].be; a_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_gnt", i), a_gnt, 1);
      chk($sformatf("v%0d_en", i), a_en, vecs[i].en);
      chk($sformatf("v%0d_baddr", i), a_baddr, {51'h0, vecs[i].addr[12:0]});
      chk($sformatf("v%0d_bwe", i), a_bwe, vecs[i].we);
      chk($sformatf("v%0d_bbe", i), a_bbe, vecs[i].be);
      chk($sformatf("v%0d_bwdata", i), a_bwdata, vecs[i].wdata);
      chk($sformatf("v%0d_rvalid_pre", i), a_rvalid, 0);
      @(negedge clk);
      a_req = 0;
      chk($sformatf("v%0d_rvalid", i), a_rvalid, 1);
      chk($sformatf("v%0d_err", i), a_err, vecs[i].err);
      chk($sformatf("v%0d_rdata", i), a_rdata, vecs[i].rdata);
      $display("vec %0d addr=0x%0h we=%0d -> rvalid=%0d err=%0d rdata=0x%08h",
               i, vecs[i].addr, vecs[i].we, a_rvalid, a_err, a_rdata);
    end
    @(negedge clk);
    chk("idle_rvalid", a_rvalid, 0);

    // Slow ROM read: hold value captured in first WAIT cycle
    a_req = 1; a_addr = 15'h0010; a_we = 0; #1;
    chk("slow_gnt", a_gnt, 1);
    chk("slow_en", a_en, 4'b0001);
    @(negedge clk);
    a_addr = 15'h2004;
    chk("slow_w1_gnt", a_gnt, 0);
    chk("slow_w1_en", a_en, 0);
    chk("slow_w1_rvalid", a_rvalid, 0);
    @(negedge clk);
    a_bank[0] = 32'hBAD0BAD0;
    chk("slow_w2_gnt", a_gnt, 0);
    chk("slow_w2_rvalid", a_rvalid, 0);
    a_req = 0;
    @(negedge clk);
    chk("slow_rvalid", a_rvalid, 1);
    chk("slow_rdata", a_rdata, 32'h00000013);
    chk("slow_err", a_err, 0);
    $display("slow read 0x0010 -> rvalid=%0d rdata=0x%08h", a_rvalid, a_rdata);
    a_bank[0] = 32'h00000013;
    @(negedge clk);
    chk("slow_after_rvalid", a_rvalid, 0);

    // Back-to-back reads to banks 1,2,3,1
    begin
      logic [14:0] bb_addr [4];
      logic [31:0] bb_exp [4];
      logic [3:0]  bb_en [4];
      bb_addr[0] = 15'h2000; bb_exp[0] = 32'hDEADBEEF; bb_en[0] = 4'b0010;
      bb_addr[1] = 15'h4000; bb_exp[1] = 32'h22222222; bb_en[1] = 4'b0100;
      bb_addr[2] = 15'h6000; bb_exp[2] = 32'h33333333; bb_en[2] = 4'b1000;
      bb_addr[3] = 15'h2100; bb_exp[3] = 32'hDEADBEEF; bb_en[3] = 4'b0010;
      for (int k = 0; k <= 4; k++) begin
        if (k < 4) begin
          a_req = 1; a_addr = bb_addr[k]; a_we = 0;
        end else begin
          a_req = 0;
        end
        #1;
        if (k < 4) begin
          chk($sformatf("b2b%0d_gnt", k), a_gnt, 1);
          chk($sformatf("b2b%0d_en", k), a_en, bb_en[k]);
        end
        if (k > 0) begin
          chk($sformatf("b2b%0d_rvalid", k - 1), a_rvalid, 1);
          chk($sformatf("b2b%0d_rdata", k - 1), a_rdata, bb_exp[k-1]);
          $display("b2b rsp %0d rdata=0x%08h", k - 1, a_rdata);
        end
        @(negedge clk);
      end
      chk("b2b_end_rvalid", a_rvalid, 0);
    end

    // Reset during the first WAIT cycle drops the response
    a_req = 1; a_addr = 15'h0010; a_we = 0;
    @(negedge clk);
    a_req = 0;
    rst_n = 0; #1;
    chk("rstw_rvalid", a_rvalid, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rstw_norsp%0d", k), a_rvalid, 0);
      @(negedge clk);
    end
    a_req = 1; a_addr = 15'h4000; #1;
    chk("rstw_gnt", a_gnt, 1);
    chk("rstw_en", a_en, 4'b0100);
    @(negedge clk);
    a_req = 0;
    chk("rstw_rvalid_after", a_rvalid, 1);
    chk("rstw_rdata_after", a_rdata, 32'h22222222);
    chk("rstw_err_after", a_err, 0);
    $display("post-reset read 0x4000 -> rvalid=%0d rdata=0x%08h", a_rvalid, a_rdata);

    // DUT B: 3 banks, out-of-range read and a RAM write
    @(negedge clk);
    b_req = 1; b_addr = 15'h6000; b_we = 0; #1;
    chk("b_oor_gnt", b_gnt, 1);
    chk("b_oor_en", b_en, 0);
    @(negedge clk);
    b_req = 0;
    chk("b_oor_rvalid", b_rvalid, 1);
    chk("b_oor_err", b_err, 1);
    chk("b_oor_rdata", b_rdata, 0);
    $display("B read 0x6000 -> rvalid=%0d err=%0d", b_rvalid, b_err);
    @(negedge clk);
    b_req = 1; b_addr = 15'h4008; b_we = 1; b_be = 4'hF; b_wdata = 32'h0BADCAFE; #1;
    chk("b_wr_en", b_en, 3'b100);
    chk("b_wr_bwe", b_bwe, 1);
    chk("b_wr_baddr", b_baddr, 13'h0008);
    @(negedge clk);
    b_req = 0;
    chk("b_wr_rvalid", b_rvalid, 1);
    chk("b_wr_err", b_err, 0);
    chk("b_wr_rdata", b_rdata, 0);
    $display("B write 0x4008 -> rvalid=%0d err=%0d", b_rvalid, b_err);
    @(negedge clk);
    chk("b_end_rvalid", b_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_bank_mux.md
Name: instr_mem_bank_mux

Overview:
- Parametrised instruction-memory front end that splits one request port across NUM_BANKS memory banks by address decode.
- Bank 0 is optionally the read-only boot ROM. Banks flagged in SLOW_BANK_MASK get extra response wait states.
- Uses a req/gnt/rvalid handshake, with error responses for illegal accesses.
- Sits between the core instruction interface (or AXI slave adapter) and the boot ROM / SRAM bank wrappers.

Parameters:
- NUM_BANKS, 4: number of banks, at least 2.
- BANK_ADDR_WIDTH, 13: byte-address width inside one bank.
- ADDR_WIDTH, BANK_ADDR_WIDTH+$clog2(NUM_BANKS): request address width.
- DATA_WIDTH, 32: data width, multiple of 8.
- ROM_BANK_EN, 1: when 1, bank 0 is read-only.
- SLOW_BANK_MASK, 'b0001: bit i set means bank i is slow.
- WAIT_CYCLES, 2: extra response cycles for slow banks. 0 makes every bank fast.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted
- addr_i  in  ADDR_WIDTH  byte address
- we_i  in  1  write enable
- be_i  in  DATA_WIDTH/8  byte enables
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid, one per granted request
- rdata_o  out  DATA_WIDTH  read data
- err_o  out  1  error flag, qualified by rvalid_o
- bank_en_o  out  NUM_BANKS  one-hot bank enable
- bank_addr_o  out  BANK_ADDR_WIDTH  addr_i[BANK_ADDR_WIDTH-1:0]
- bank_we_o  out  1  we_i passed through
- bank_be_o  out  DATA_WIDTH/8  be_i passed through
- bank_wdata_o  out  DATA_WIDTH  wdata_i passed through
- bank_rdata_i  in  NUM_BANKS*DATA_WIDTH  bank read data, bank i at slice [i*DATA_WIDTH +: DATA_WIDTH]. Valid one cycle after the bank enable and held until that bank's next enable.

Reset: rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Decode: sel = addr_i[ADDR_WIDTH-1:BANK_ADDR_WIDTH].
- Illegal access when either holds:
  - sel >= NUM_BANKS;
  - ROM_BANK_EN=1 and sel=0 and we_i=1.
- FSM states are IDLE, RSP and WAIT.
- gnt_o = req_i in IDLE and RSP; gnt_o = 0 in WAIT. A handshake is req_i & gnt_o.
- On handshake:
  - bank_en_o[sel] = 1 in that same cycle, only if the access is legal. Otherwise bank_en_o = 0.
  - Register sel_q, we_q, err_q and slow_q. slow_q = SLOW_BANK_MASK[sel] & (WAIT_CYCLES>0) & ~err & ~we_i.
- Next state after a handshake:
  - slow_q: go to WAIT, load cnt = WAIT_CYCLES.
  - otherwise: go to RSP.
- No handshake while in IDLE or RSP: go to IDLE.
- WAIT:
  - First WAIT cycle: hold_q <= bank_rdata_i[sel_q].
  - cnt decrements every cycle. cnt==1 moves to RSP.
  - req_i is ignored (not granted) while in WAIT.
- RSP: rvalid_o = 1 for exactly one cycle per transaction. err_o = err_q.
- Read data in RSP:
  - Fast legal read: rdata_o = bank_rdata_i[sel_q].
  - Slow read: rdata_o = hold_q.
  - Writes and errors: rdata_o = 0.
- Latency:
  - Fast read, write and error: rvalid_o at grant cycle+1.
  - Slow read: rvalid_o at grant cycle+1+WAIT_CYCLES.
  - Fast back-to-back requests sustain 1 transaction per cycle, because a new grant is allowed in the RSP cycle.
- A write to a RAM bank gets rvalid_o=1, err_o=0, rdata_o=0.
- An error access gets rvalid_o=1, err_o=1, and no bank is enabled.
- Outside RSP: rvalid_o=0, err_o=0, rdata_o=0.
- Reset values: state=IDLE; rvalid_o, err_o, cnt, hold_q, sel_q, we_q, err_q and slow_q all 0. gnt_o=req_i. bank_en_o=0 unless a handshake occurs.
- Reset mid-transaction (WAIT or RSP): the outstanding response is dropped and no rvalid_o is produced after reset.
- At most one transaction is outstanding. Order is strictly preserved.

Test Plan:
- After reset, req_i=1, addr=0x2004 (bank 1), read, bank1 data 0xDEADBEEF -> gnt_o=1 in the same cycle, bank_en_o=0b0010, bank_addr_o=0x0004; next cycle rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0.
- Read addr=0x0010 (bank 0, slow, WAIT_CYCLES=2), ROM data 0x00000013 -> gnt_o=0 for the 2 WAIT cycles; rvalid_o at grant+3 with rdata_o=0x00000013, even though the ROM output changes after grant+1.
- Write 0x0020 with ROM_BANK_EN=1 -> bank_en_o=0; next cycle rvalid_o=1, err_o=1, rdata_o=0.
- NUM_BANKS=3, read addr=0x6000 -> err_o=1 response; write 0x4008 with be=0xF -> bank_en_o=0b100, bank_we_o=1, rvalid_o next cycle with err_o=0.
- 4 back-to-back reads to banks 1,2,3,1 -> 4 grants in 4 consecutive cycles; rvalid_o high for 4 consecutive cycles with in-order data.
- rst_n asserted during the first WAIT cycle -> state returns to IDLE, no rvalid_o after reset; the next read to bank 2 completes normally.
